voting_tally_ctrl: RTL
======================

Name: voting_tally_ctrl

Overview:
Sequential front-end and controller for the voting datapath. Accepts one ballot per cycle from 2**M voters over a valid/ready handshake and enforces one vote per voter ID. Keeps per-candidate tallies, then scans them to report the plurality winner and its count. It replaces the all-votes-parallel bus with a serial, resource-shared tally.

Parameters:
N, 3, candidate ID width (2**N candidates)
M, 3, voter ID width (2**M voters)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; clears tallies and opens an election
close  in  1  single-cycle pulse; ends collection early
vote_valid  in  1  ballot present
vote_ready  out  1  controller accepts ballot this cycle
vote_id  in  M  voter index
vote_val  in  N  candidate voted for
busy  out  1  high in COLLECT or SCAN
done  out  1  high in DONE; winner outputs valid
winner  out  N  winning candidate
winner_count  out  M+1  votes for winner
ballots  out  M+1  accepted ballots this election
dup_err  out  1  one-cycle pulse: duplicate voter rejected

Behaviour:
- Reset (async, rst_n=0): state IDLE. All tallies, voted bitmap, ballots, winner, winner_count = 0. vote_ready, busy, done, dup_err = 0.
- States: IDLE, COLLECT, SCAN, DONE.
- IDLE: start=1 -> COLLECT; clears tallies[0..2**N-1] (each M+1 bits), the 2**M-bit voted bitmap and ballots. close is ignored.
- COLLECT: vote_ready=1 combinationally from state only.
  - Acceptance: vote_valid & vote_ready.
  - If voted[vote_id]=0: tallies[vote_val]+=1, voted[vote_id]=1, ballots+=1.
  - If voted[vote_id]=1: no tally change; dup_err=1 on the next cycle, for one cycle.
  - Exit to SCAN when ballots reaches 2**M after an accept, or when close=1.
  - close and an accepted vote in the same cycle: the vote counts, then SCAN.
  - start in COLLECT is ignored.
- SCAN: vote_ready=0.
  - Index i runs 0..2**N-1, one candidate per cycle.
  - Running best starts at index 0, count 0.
  - Replace best only if tallies[i] > best count (strict), so ties go to the lowest candidate index.
  - After i=2**N-1 is evaluated -> DONE; winner and winner_count are registered on entry to DONE.
- DONE: done=1 and outputs held until start.
  - start -> COLLECT with a full clear; done drops the next cycle.
  - Zero-ballot election yields winner=0, winner_count=0.
- Latency: last accept (or close) at cycle k -> SCAN from k+1 -> done=1 at cycle k+1+2**N.
- Arithmetic: tallies and ballots are M+1 bits and cannot overflow, since the bitmap limits ballots to 2**M.
- Reset mid-operation: returns to IDLE immediately and discards the partial election.

Decomposition:
- Shared package holds:
  - state enum (IDLE/COLLECT/SCAN/DONE)
  - widths derived from N, M (NUM_CAND=2**N, NUM_VOTER=2**M, CNT_W=M+1)
- One sub-module, voting_max_scan: the sequential argmax over the tally array, with start/index/best registers and a done flag.
- Tally array and voted bitmap stay in the top module.

Test Plan:
1. Ballots 6,6,1,1,7,7,7,2 from voters 0..7 -> done at last accept+1+8 cycles; winner=7, winner_count=3, ballots=8.
2. Ballots 7,7,1,4,4,4,4,2 -> winner=4, count=4. Then start again with 6,0,1,7,4,3,2,2 -> winner=2, count=2; check the prior tallies were cleared.
3. Tie: 6,6,1,4,5,3,5,7 -> 5 and 6 both have 2 votes; winner=5 (lowest index), count=2.
4. Duplicate: voter 3 votes 1, then voter 3 votes 7 -> one-cycle dup_err pulse; tally[7] unchanged; ballots increments once; election still needs all 8 distinct voters to auto-close.
5. Early close:
   - 3 ballots (2,2,5), then close -> winner=2, count=2, ballots=3.
   - close immediately after start -> winner=0, count=0.
   - close in the same cycle as the 3rd ballot -> that ballot is counted.
6. Reset/robustness:
   - rst_n low mid-COLLECT after 4 ballots -> all outputs 0, state IDLE; next election is unaffected.
   - vote_valid held high during SCAN/DONE -> vote_ready=0, no tally change.
   - start during COLLECT is ignored.

Source files
------------

// File: rtl/voting_tally_ctrl_pkg.sv
// Shared types and width helpers for the voting tally controller.
package voting_tally_ctrl_pkg;

  localparam int DEF_N = 3;
  localparam int DEF_M = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_SCAN,
    ST_DONE
  } state_t;

  function automatic int num_cand(input int n);
    return 1 << n;
  endfunction

  function automatic int num_voter(input int m);
    return 1 << m;
  endfunction

  // Counters carry one extra bit so a full house of 2**M ballots fits.
  function automatic int cnt_w(input int m);
    return m + 1;
  endfunction

  localparam int NUM_CAND  = num_cand(DEF_N);
  localparam int NUM_VOTER = num_voter(DEF_M);
  localparam int CNT_W     = cnt_w(DEF_M);

endpackage

// File: rtl/voting_max_scan.sv
// Sequential argmax over the tally array, one candidate per cycle.
module voting_max_scan
  import voting_tally_ctrl_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = DEF_M
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [M:0]   tally,
  output logic [N-1:0] idx,
  output logic         last,
  output logic [N-1:0] best_idx_nxt,
  output logic [M:0]   best_cnt_nxt
);

  logic         active;
  logic [N-1:0] best_idx;
  logic [M:0]   best_cnt;

  // Strict compare keeps the lowest index on a tie.
  always_comb begin
    best_idx_nxt = best_idx;
    best_cnt_nxt = best_cnt;
    if (tally > best_cnt) begin
      best_idx_nxt = idx;
      best_cnt_nxt = tally;
    end
  end

  assign last = active && (idx == {N{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      idx      <= '0;
      best_idx <= '0;
      best_cnt <= '0;
    end else if (start) begin
      active   <= 1'b1;
      idx      <= '0;
      best_idx <= '0;
      best_cnt <= '0;
    end else if (active) begin
      best_idx <= best_idx_nxt;
      best_cnt <= best_cnt_nxt;
      if (last) active <= 1'b0;
      else      idx    <= idx + N'(1);
    end
  end

endmodule

// File: rtl/voting_tally_ctrl.sv
// Serial ballot collector with one-vote-per-voter enforcement and plurality scan.
//   state      | meaning
//   ST_IDLE    | waiting for start, no election open
//   ST_COLLECT | accepting ballots
//   ST_SCAN    | argmax over tallies, one candidate per cycle
//   ST_DONE    | winner outputs valid until next start
module voting_tally_ctrl
  import voting_tally_ctrl_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = DEF_M
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         close,
  input  logic         vote_valid,
  output logic         vote_ready,
  input  logic [M-1:0] vote_id,
  input  logic [N-1:0] vote_val,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] winner,
  output logic [M:0]   winner_count,
  output logic [M:0]   ballots,
  output logic         dup_err
);

  localparam int L_NUM_CAND  = num_cand(N);
  localparam int L_NUM_VOTER = num_voter(M);
  localparam int L_CNT_W     = cnt_w(M);

  state_t                   state, state_nxt;
  logic [L_CNT_W-1:0]       tallies [L_NUM_CAND];
  logic [L_NUM_VOTER-1:0]   voted;
  logic                     accept, fresh, clear, scan_start, scan_last;
  logic [N-1:0]             scan_idx, scan_best_idx;
  logic [L_CNT_W-1:0]       scan_best_cnt;

  assign vote_ready = (state == ST_COLLECT);
  assign busy       = (state == ST_COLLECT) || (state == ST_SCAN);
  assign done       = (state == ST_DONE);
  assign accept     = vote_valid && vote_ready;
  assign fresh      = accept && !voted[vote_id];
  assign clear      = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign scan_start = (state == ST_COLLECT) && (state_nxt == ST_SCAN);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_COLLECT;
      ST_COLLECT: if (close || (fresh && ballots == L_CNT_W'(L_NUM_VOTER - 1)))
                    state_nxt = ST_SCAN;
      ST_SCAN:    if (scan_last) state_nxt = ST_DONE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // A vote that lands together with close is still counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < L_NUM_CAND; i++) tallies[i] <= '0;
      voted        <= '0;
      ballots      <= '0;
      dup_err      <= 1'b0;
      winner       <= '0;
      winner_count <= '0;
    end else begin
      dup_err <= accept && voted[vote_id];
      if (clear) begin
        for (int i = 0; i < L_NUM_CAND; i++) tallies[i] <= '0;
        voted   <= '0;
        ballots <= '0;
      end else if (fresh) begin
        tallies[vote_val] <= tallies[vote_val] + L_CNT_W'(1);
        voted[vote_id]    <= 1'b1;
        ballots           <= ballots + L_CNT_W'(1);
      end
      if ((state == ST_SCAN) && scan_last) begin
        winner       <= scan_best_idx;
        winner_count <= scan_best_cnt;
      end
    end
  end

  voting_max_scan #(.N(N), .M(M)) u_scan (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (scan_start),
    .tally        (tallies[scan_idx]),
    .idx          (scan_idx),
    .last         (scan_last),
    .best_idx_nxt (scan_best_idx),
    .best_cnt_nxt (scan_best_cnt)
  );

endmodule
